// File: rtl/strait_pkg.sv
// Shared definitions for the STRAIT self-test sequencer.
//  - state_t: sequencer FSM states
//  - default array dimension, pattern depths and line-fault threshold
//  - small integer helpers used to size ports and counters
package strait_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RESP = 3'd2,
        WRITEBACK = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int STRAIT_SYSTOLIC_SIZE        = 8;
    localparam int STRAIT_SA_DEPTH             = 12;
    localparam int STRAIT_TD_DEPTH             = 18;
    localparam int STRAIT_LINE_FAULT_THRESHOLD = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width that never collapses to zero bits for tiny depths.
    function automatic int index_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/strait_line_fault_counter.sv
// Population count of one row or column of the fault map, with a threshold
// compare deciding whether the whole line is treated as faulty.
// Ports:
//  line_bits   in   WIDTH  fault bits of one row or column
//  line_fault  out  1      popcount(line_bits) >= THRESHOLD
module strait_line_fault_counter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4,
    parameter int THRESHOLD = 2
) (
    input  logic [WIDTH-1:0] line_bits,
    output logic             line_fault
);

    logic [CNT_WIDTH-1:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_WIDTH'(line_bits[i]);
        end
    end

    assign line_fault = (int'(count) >= THRESHOLD);

endmodule

// File: rtl/strait_test_sequencer.sv
// STRAIT systolic-array self-test sequencer.
// On start it walks every stuck-at (SA) pattern and then every
// transition-delay (TD) pattern, presenting test_type/test_counter to the
// eNVM pattern store and handing each pattern to the scan driver with a
// valid/ready handshake. Each comparator response is ORed into an N x N fault
// map, which is then written back to eNVM fault storage one row per cycle
// together with per-row and per-column line-fault flags.
//
// Build option: define STRAIT_SEQ_TD_TEST_EN to include the TD phase. Without
// it the FSM goes straight from the last SA pattern to writeback and
// test_type is tied to 0.
//
// Ports:
//  clk, rst                  clock, synchronous active-high reset
//  start                     begin a run (only honoured in IDLE)
//  busy / done / fault_found run status; done is a one-cycle pulse
//  test_type, test_counter   eNVM pattern select (0 = SA, 1 = TD) and index
//  pattern_valid/ready       handshake to the scan driver
//  resp_valid, resp_pe_fault comparator result, bit r*N+c = PE(r,c)
//  detection_en, counter     eNVM fault-storage write enable and row index
//  single_pe_detection       fault map row [counter]
//  row/column_fault_detection line flags for row/column [counter]
module strait_test_sequencer
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE         = STRAIT_SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH            = index_width(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH = STRAIT_SA_DEPTH,
    parameter int TD_TEST_PATTERN_DEPTH = STRAIT_TD_DEPTH,
    parameter int MAX_ADDR_WIDTH        = index_width(max_int(SA_TEST_PATTERN_DEPTH,
                                                              TD_TEST_PATTERN_DEPTH)),
    parameter int LINE_FAULT_THRESHOLD  = STRAIT_LINE_FAULT_THRESHOLD
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   fault_found,
    output logic                                   test_type,
    output logic [MAX_ADDR_WIDTH-1:0]              test_counter,
    output logic                                   pattern_valid,
    input  logic                                   pattern_ready,
    input  logic                                   resp_valid,
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] resp_pe_fault,
    output logic                                   detection_en,
    output logic [ADDR_WIDTH-1:0]                  counter,
    output logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
    output logic                                   row_fault_detection,
    output logic                                   column_fault_detection
);

    localparam int N      = SYSTOLIC_SIZE;
    localparam int NN     = N * N;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    localparam logic [MAX_ADDR_WIDTH-1:0] SA_LAST = MAX_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [MAX_ADDR_WIDTH-1:0] TD_LAST = MAX_ADDR_WIDTH'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [MAX_ADDR_WIDTH-1:0] TC_ONE  = MAX_ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]     ROW_LAST = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0]     ROW_ONE  = ADDR_WIDTH'(1);

    state_t                    state_reg, state_next;
    logic [NN-1:0]             map_reg, map_next;
    logic [MAX_ADDR_WIDTH-1:0] test_counter_reg, test_counter_next;
    logic [ADDR_WIDTH-1:0]     counter_reg, counter_next;
    logic                      fault_found_reg, fault_found_next;
    logic                      td_phase;

`ifdef STRAIT_SEQ_TD_TEST_EN
    logic test_type_reg, test_type_next;
    assign td_phase = test_type_reg;
`else
    assign td_phase = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            map_reg          <= '0;
            test_counter_reg <= '0;
            counter_reg      <= '0;
            fault_found_reg  <= 1'b0;
`ifdef STRAIT_SEQ_TD_TEST_EN
            test_type_reg    <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            map_reg          <= map_next;
            test_counter_reg <= test_counter_next;
            counter_reg      <= counter_next;
            fault_found_reg  <= fault_found_next;
`ifdef STRAIT_SEQ_TD_TEST_EN
            test_type_reg    <= test_type_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        map_next          = map_reg;
        test_counter_next = test_counter_reg;
        counter_next      = counter_reg;
        fault_found_next  = fault_found_reg;
`ifdef STRAIT_SEQ_TD_TEST_EN
        test_type_next    = test_type_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    map_next          = '0;
                    test_counter_next = '0;
                    counter_next      = '0;
                    fault_found_next  = 1'b0;
`ifdef STRAIT_SEQ_TD_TEST_EN
                    test_type_next    = 1'b0;
`endif
                    state_next        = ISSUE;
                end
            end

            ISSUE: begin
                // test_type/test_counter are only touched in WAIT_RESP, so they
                // stay stable for as long as the scan driver stalls us here.
                if (pattern_ready) begin
                    state_next = WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                if (resp_valid) begin
                    map_next = map_reg | resp_pe_fault;
                    if (!td_phase && (test_counter_reg == SA_LAST)) begin
`ifdef STRAIT_SEQ_TD_TEST_EN
                        test_type_next    = 1'b1;
                        test_counter_next = '0;
                        state_next        = ISSUE;
`else
                        test_counter_next = '0;
                        counter_next      = '0;
                        state_next        = WRITEBACK;
`endif
                    end else if (td_phase && (test_counter_reg == TD_LAST)) begin
`ifdef STRAIT_SEQ_TD_TEST_EN
                        test_type_next    = 1'b0;
`endif
                        test_counter_next = '0;
                        counter_next      = '0;
                        state_next        = WRITEBACK;
                    end else begin
                        test_counter_next = test_counter_reg + TC_ONE;
                        state_next        = ISSUE;
                    end
                end
            end

            WRITEBACK: begin
                if (counter_reg == ROW_LAST) begin
                    counter_next     = '0;
                    // Loaded on the way into DONE so it is valid alongside done.
                    fault_found_next = |map_reg;
                    state_next       = DONE;
                end else begin
                    counter_next = counter_reg + ROW_ONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row / column extraction and line-fault flags
    // ------------------------------------------------------------------
    logic [N-1:0] row_bits;
    logic [N-1:0] col_bits;
    logic         row_flag;
    logic         col_flag;

    always_comb begin
        row_bits = map_reg[int'(counter_reg) * N +: N];
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_col
            assign col_bits[gi] = map_reg[gi * N + int'(counter_reg)];
        end
    endgenerate

    strait_line_fault_counter #(
        .WIDTH     (N),
        .CNT_WIDTH (CNT_W),
        .THRESHOLD (LINE_FAULT_THRESHOLD)
    ) u_row_counter (
        .line_bits  (row_bits),
        .line_fault (row_flag)
    );

    strait_line_fault_counter #(
        .WIDTH     (N),
        .CNT_WIDTH (CNT_W),
        .THRESHOLD (LINE_FAULT_THRESHOLD)
    ) u_col_counter (
        .line_bits  (col_bits),
        .line_fault (col_flag)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy          = (state_reg == ISSUE) || (state_reg == WAIT_RESP) ||
                           (state_reg == WRITEBACK);
    assign done          = (state_reg == DONE);
    assign pattern_valid = (state_reg == ISSUE);
    assign detection_en  = (state_reg == WRITEBACK);
    assign fault_found   = fault_found_reg;
    assign test_counter  = test_counter_reg;
    assign counter       = counter_reg;

`ifdef STRAIT_SEQ_TD_TEST_EN
    assign test_type = test_type_reg;
`else
    assign test_type = 1'b0;
`endif

    // Fault-storage data is forced to zero whenever no write is in progress.
    assign single_pe_detection    = detection_en ? row_bits : '0;
    assign row_fault_detection    = detection_en & row_flag;
    assign column_fault_detection = detection_en & col_flag;

endmodule
